mac_row_stage: RTL and testbench

MAC_ROW_STAGE -- requirements
Module: mac_row_stage

---
 rtl/ode_accel_pkg.sv | 12 +
 rtl/mac_unit.sv | 33 +++
 rtl/mac_row_stage.sv | 125 ++++++++++++
 tb/tb_mac_row_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ode_accel_pkg.sv
// Shared widths and FSM encodings for the ODE accelerator datapath stages.
package ode_accel_pkg;
  localparam int DATA_SIZE = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_SIZE  = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/mac_unit.sv
// Signed multiply, sign-extend and accumulate for one dot product.
// acc is the running sum including the current beat, so the owner can take a
// row total on the same edge that clears the register.
module mac_unit
  import ode_accel_pkg::*;
#(
  parameter int DATA_SIZE = ode_accel_pkg::DATA_SIZE,
  parameter int ACC_SIZE  = ode_accel_pkg::ACC_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] b,
  output logic signed [ACC_SIZE-1:0]  acc
);
  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]    prod_ext;
  logic signed [ACC_SIZE-1:0]    acc_q;
  logic signed [ACC_SIZE-1:0]    acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_SIZE-2*DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
  assign acc      = en ? (acc_q + prod_ext) : acc_q;
  // Clear wins: the beat taken with clr is already folded into acc for the owner.
  assign acc_d    = clr ? '0 : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

// File: rtl/mac_row_stage.sv
// Row-by-row matrix-vector MAC stage: accumulates N_COLS products per row and
// reports each row as a saturated fixed-point result one cycle after its last beat.
module mac_row_stage
  import ode_accel_pkg::*;
#(
  parameter int DATA_SIZE = ode_accel_pkg::DATA_SIZE,
  parameter int FRAC_BITS = ode_accel_pkg::FRAC_BITS,
  parameter int N_COLS    = 4,
  parameter int N_ROWS    = 4,
  parameter int ACC_SIZE  = ode_accel_pkg::ACC_SIZE,
  localparam int CW       = (N_COLS > 1) ? $clog2(N_COLS) : 1,
  localparam int RW       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] data_mat,
  input  logic [DATA_SIZE-1:0] data_vec,
  output logic                 fetch_enable,
  output logic                 finished_one_row,
  output logic                 final_done,
  output logic [DATA_SIZE-1:0] row_result,
  output logic                 row_result_valid,
  output logic [RW-1:0]        row_index,
  output logic                 busy
);
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
    {{(ACC_SIZE-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN =
    {{(ACC_SIZE-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [DATA_SIZE-1:0] result_q, result_d;
  logic [RW-1:0]        index_q, index_d;
  logic                 rvalid_q, final_q;

  logic                       beat, last_col, last_row;
  logic signed [ACC_SIZE-1:0] acc_sum, shifted;
  logic [DATA_SIZE-1:0]       sat_val;

  assign beat     = (state_q == ST_RUN) && in_valid;
  assign last_col = beat && (col_q == CW'(N_COLS-1));
  assign last_row = (row_q == RW'(N_ROWS-1));

  mac_unit #(.DATA_SIZE(DATA_SIZE), .ACC_SIZE(ACC_SIZE)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (((state_q == ST_IDLE) && start) || last_col),
    .en    (beat),
    .a     (data_mat),
    .b     (data_vec),
    .acc   (acc_sum)
  );

  assign shifted = acc_sum >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[DATA_SIZE-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_SIZE-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_SIZE-1:0];
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    result_d = last_col ? sat_val : result_q;
    index_d  = last_col ? row_q : index_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else if (beat) begin
          col_d = col_q + 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      result_q <= '0;
      index_q  <= '0;
      rvalid_q <= 1'b0;
      final_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      result_q <= result_d;
      index_q  <= index_d;
      rvalid_q <= last_col;
      final_q  <= last_col && last_row;
    end
  end

  assign fetch_enable     = (state_q == ST_RUN);
  assign busy             = (state_q != ST_IDLE);
  assign row_result       = result_q;
  assign row_result_valid = rvalid_q;
  assign finished_one_row = rvalid_q;
  assign final_done       = final_q;
  assign row_index        = index_q;
endmodule

// File: tb/tb_mac_row_stage.sv
// Directed bench for mac_row_stage: products, saturation, gaps, ignored inputs, reset.
module tb_mac_row_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_mat = '0;
  logic [15:0] data_vec = '0;
  logic        fetch_enable, finished_one_row, final_done, row_result_valid, busy;
  logic [15:0] row_result;
  logic [1:0]  row_index;

  int tests = 0;
  int fails = 0;

  mac_row_stage dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_valid         (in_valid),
    .data_mat         (data_mat),
    .data_vec         (data_vec),
    .fetch_enable     (fetch_enable),
    .finished_one_row (finished_one_row),
    .final_done       (final_done),
    .row_result       (row_result),
    .row_result_valid (row_result_valid),
    .row_index        (row_index),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] m, input logic [15:0] v);
    in_valid = 1'b1;
    data_mat = m;
    data_vec = v;
    tick();
    in_valid = 1'b0;
    data_mat = '0;
    data_vec = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // m[0]/v[0] is column 0; result checked on the cycle right after the 4th beat.
  task automatic run_row(input logic [3:0][15:0] m, input logic [3:0][15:0] v,
                         input logic [15:0] exp_res, input logic [1:0] idx,
                         input logic fin, input int gap);
    for (int c = 0; c < 4; c++) begin
      beat(m[c], v[c]);
      if (c < 3) begin
        chk("rv_mid_row", 32'(row_result_valid), 32'h0);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("rv_in_gap", 32'(row_result_valid), 32'h0);
        end
      end
    end
    chk("row_result", 32'(row_result), 32'(exp_res));
    chk("row_valid", 32'(row_result_valid), 32'h1);
    chk("finished_one_row", 32'(finished_one_row), 32'h1);
    chk("row_index", 32'(row_index), 32'(idx));
    chk("final_done", 32'(final_done), 32'(fin));
  endtask

  task automatic basic_product();
    pulse_start();
    chk("busy_run", 32'(busy), 32'h1);
    chk("fetch_run", 32'(fetch_enable), 32'h1);
    for (int r = 0; r < 4; r++)
      run_row({4{16'h0100}}, {4{16'h0200}}, 16'h0800, 2'(r), (r == 3), 0);
    chk("busy_flush", 32'(busy), 32'h1);
    chk("fetch_flush", 32'(fetch_enable), 32'h0);
    tick();
    chk("busy_idle", 32'(busy), 32'h0);
    chk("final_drop", 32'(final_done), 32'h0);
    chk("valid_drop", 32'(row_result_valid), 32'h0);
    chk("result_hold", 32'(row_result), 32'h0800);
  endtask

  initial begin
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst_result", 32'(row_result), 32'h0);
    chk("rst_valid", 32'(row_result_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fetch", 32'(fetch_enable), 32'h0);
    chk("rst_index", 32'(row_index), 32'h0);
    reset = 1'b0;
    tick();

    // Basic product: 4 x (1.0*2.0) = 8.0 per row; busy drops 2 cycles after the last beat.
    basic_product();

    // Saturation, mixed sign with 3-cycle gaps, start pulse ignored mid-row.
    pulse_start();
    run_row({4{16'h7F00}}, {4{16'h7F00}}, 16'h7FFF, 2'd0, 1'b0, 0);
    run_row({4{16'h8000}}, {4{16'h7F00}}, 16'h8000, 2'd1, 1'b0, 0);
    // -1.5 + 1.0 - 1.0 + 0 = -1.5
    run_row({16'h0000, 16'h0200, 16'h0100, 16'hFF00},
            {16'h0000, 16'hFF80, 16'h0100, 16'h0180}, 16'hFE80, 2'd2, 1'b0, 3);
    tick();
    chk("gap_single_pulse", 32'(row_result_valid), 32'h0);
    chk("gap_result_hold", 32'(row_result), 32'hFE80);
    beat(16'h0100, 16'h0100);
    beat(16'h0100, 16'h0100);
    pulse_start();
    chk("start_in_run_busy", 32'(busy), 32'h1);
    chk("start_in_run_fetch", 32'(fetch_enable), 32'h1);
    chk("start_in_run_valid", 32'(row_result_valid), 32'h0);
    beat(16'h0100, 16'h0100);
    chk("start_in_run_mid", 32'(row_result_valid), 32'h0);
    beat(16'h0100, 16'h0100);
    chk("start_in_run_result", 32'(row_result), 32'h0400);
    chk("start_in_run_index", 32'(row_index), 32'h3);
    chk("start_in_run_final", 32'(final_done), 32'h1);
    tick();

    // in_valid in IDLE is ignored.
    for (int i = 0; i < 5; i++) begin
      beat(16'h7F00, 16'h7F00);
      chk("idle_valid", 32'(row_result_valid), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end
    chk("idle_result_hold", 32'(row_result), 32'h0400);

    // Continuous beats across row boundaries with distinct row sums.
    pulse_start();
    run_row({4{16'h0100}}, {4{16'h0100}}, 16'h0400, 2'd0, 1'b0, 0);
    run_row({4{16'h0100}}, {4{16'h0080}}, 16'h0200, 2'd1, 1'b0, 0);
    run_row({4{16'hFF00}}, {4{16'h0100}}, 16'hFC00, 2'd2, 1'b0, 0);
    run_row({4{16'h0000}}, {4{16'h0000}}, 16'h0000, 2'd3, 1'b1, 0);
    tick();
    chk("boundary_idle", 32'(busy), 32'h0);

    // Reset after 6 beats: everything zero before the next clock edge.
    pulse_start();
    run_row({4{16'h0100}}, {4{16'h0200}}, 16'h0800, 2'd0, 1'b0, 0);
    beat(16'h0100, 16'h0200);
    beat(16'h0100, 16'h0200);
    reset = 1'b1;
    #1;
    chk("arst_fetch", 32'(fetch_enable), 32'h0);
    chk("arst_finished", 32'(finished_one_row), 32'h0);
    chk("arst_final", 32'(final_done), 32'h0);
    chk("arst_result", 32'(row_result), 32'h0);
    chk("arst_valid", 32'(row_result_valid), 32'h0);
    chk("arst_index", 32'(row_index), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("no_autostart", 32'(busy), 32'h0);
    chk("no_pulse_after_rst", 32'(row_result_valid), 32'h0);
    basic_product();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
